// File: rtl/layer_4_pkg.sv
// ---------------------------------------------------------------------------
// layer_4_pkg
// Shared definitions for the layer-4 channel-reduce datapath.
//   - fp32_t          : raw IEEE-754 single-precision bit pattern
//   - FP32_* fields   : sign / exponent / mantissa bit positions
//   - FP32_QNAN       : canonical quiet NaN produced by every invalid add
//   - frame_pixels()  : pixel count of a square output feature map
// ---------------------------------------------------------------------------
package layer_4_pkg;

    typedef logic [31:0] fp32_t;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_MAN_LSB  = 0;

    localparam logic [7:0] FP32_EXP_MAX  = 8'hFF;
    localparam fp32_t      FP32_QNAN     = 32'h7FC00000;
    localparam fp32_t      FP32_NEG_ZERO = 32'h80000000;

    // Number of pixels in one side x side output frame.
    function automatic int frame_pixels(input int side);
        return side * side;
    endfunction

endpackage

// File: rtl/fp32_add.sv
// ---------------------------------------------------------------------------
// fp32_add
// Combinational two-operand FP32 adder.
//   a_i, b_i : FP32 operands
//   sum_o    : FP32 sum
// Behaviour: round to nearest even, denormal operands/results flushed to
// signed zero, overflow to +/-Inf, any NaN or Inf-Inf gives the canonical
// quiet NaN, an exact zero sum is +0.0.
// ---------------------------------------------------------------------------
module fp32_add
    import layer_4_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t sum_o
);

    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_man, b_man;

    assign a_sign = a_i[FP32_SIGN_BIT];
    assign b_sign = b_i[FP32_SIGN_BIT];
    assign a_exp  = a_i[FP32_EXP_MSB:FP32_EXP_LSB];
    assign b_exp  = b_i[FP32_EXP_MSB:FP32_EXP_LSB];
    assign a_man  = a_i[FP32_MAN_MSB:FP32_MAN_LSB];
    assign b_man  = b_i[FP32_MAN_MSB:FP32_MAN_LSB];

    // Zero exponent covers both true zeros and denormals (flushed).
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (a_exp == 8'd0);
    assign b_zero = (b_exp == 8'd0);
    assign a_inf  = (a_exp == FP32_EXP_MAX) && (a_man == 23'd0);
    assign b_inf  = (b_exp == FP32_EXP_MAX) && (b_man == 23'd0);
    assign a_nan  = (a_exp == FP32_EXP_MAX) && (a_man != 23'd0);
    assign b_nan  = (b_exp == FP32_EXP_MAX) && (b_man != 23'd0);

    // Order operands by magnitude so the subtraction is never negative and
    // the result sign is simply the sign of the larger operand.
    logic        a_is_big;
    logic        big_sign;
    logic [7:0]  big_exp, sml_exp;
    logic [22:0] big_man, sml_man;
    logic        eff_sub;

    assign a_is_big = ({a_exp, a_man} >= {b_exp, b_man});
    assign big_sign = a_is_big ? a_sign : b_sign;
    assign big_exp  = a_is_big ? a_exp  : b_exp;
    assign big_man  = a_is_big ? a_man  : b_man;
    assign sml_exp  = a_is_big ? b_exp  : a_exp;
    assign sml_man  = a_is_big ? b_man  : a_man;
    assign eff_sub  = a_sign ^ b_sign;

    // Working mantissas: hidden bit, 23 fraction bits, guard/round/sticky.
    logic [7:0]         exp_diff;
    logic [26:0]        big_m, sml_m, sml_mask, sml_sh, diff, norm_m;
    logic [27:0]        sum28;
    logic [4:0]         lz;
    logic signed [9:0]  exp_w;
    logic [24:0]        rounded;
    logic               rnd, zero_res;
    logic [22:0]        frac;

    always_comb begin
        sum_o    = '0;
        exp_diff = big_exp - sml_exp;
        big_m    = {1'b1, big_man, 3'b000};
        sml_m    = {1'b1, sml_man, 3'b000};
        sml_mask = '0;
        sml_sh   = '0;
        sum28    = '0;
        diff     = '0;
        lz       = '0;
        norm_m   = '0;
        zero_res = 1'b0;
        exp_w    = {2'b00, big_exp};

        // Alignment: everything shifted out collapses into the sticky LSB.
        if (exp_diff >= 8'd27) begin
            sml_sh = 27'd1;
        end else begin
            sml_mask = (27'd1 << exp_diff) - 27'd1;
            sml_sh   = (sml_m >> exp_diff) | {26'd0, |(sml_m & sml_mask)};
        end

        if (!eff_sub) begin
            sum28 = {1'b0, big_m} + {1'b0, sml_sh};
            if (sum28[27]) begin
                norm_m = {sum28[27:2], sum28[1] | sum28[0]};
                exp_w  = exp_w + 10'sd1;
            end else begin
                norm_m = sum28[26:0];
            end
        end else begin
            // A left shift of more than one only happens when the exponents
            // differ by at most one, so no sticky bit is ever shifted up.
            diff     = big_m - sml_sh;
            zero_res = (diff == 27'd0);
            for (int i = 0; i < 27; i++) begin
                if (diff[i]) begin
                    lz = 5'(26 - i);
                end
            end
            norm_m = diff << lz;
            exp_w  = exp_w - $signed({5'd0, lz});
        end

        rnd     = norm_m[2] & (norm_m[3] | norm_m[1] | norm_m[0]);
        rounded = {1'b0, norm_m[26:3]} + {24'd0, rnd};
        if (rounded[24]) begin
            exp_w = exp_w + 10'sd1;
            frac  = rounded[23:1];
        end else begin
            frac  = rounded[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            sum_o = FP32_QNAN;
        end else if (a_inf) begin
            sum_o = a_i;
        end else if (b_inf) begin
            sum_o = b_i;
        end else if (a_zero && b_zero) begin
            sum_o = '0;
        end else if (a_zero) begin
            sum_o = b_i;
        end else if (b_zero) begin
            sum_o = a_i;
        end else if (zero_res) begin
            sum_o = '0;
        end else if (exp_w >= 10'sd255) begin
            sum_o = {big_sign, FP32_EXP_MAX, 23'd0};
        end else if (exp_w <= 10'sd0) begin
            sum_o = {big_sign, 31'd0};
        end else begin
            sum_o = {big_sign, exp_w[7:0], frac};
        end
    end

endmodule

// File: rtl/layer_4_channel_reduce.sv
// ---------------------------------------------------------------------------
// layer_4_channel_reduce
// Sums 32 FP32 per-channel convolution partials in a fixed pairwise tree,
// adds the folded batch-norm bias and applies the activation. Fully
// pipelined, 7 cycles from valid_in to valid_out, no back-pressure.
//   Clk        : clock, rising edge
//   Rst        : synchronous active-high reset
//   data_in    : 32 packed FP32 lanes, lane k at [32k+31:32k]
//   valid_in   : data_in valid
//   data_out   : FP32 output pixel
//   valid_out  : data_out valid
//   frame_last : valid_out beat is the last pixel of an IMG_SIZE^2 frame
// Build option: define LAYER_4_LEAKY_RELU_EN for leaky ReLU in stage 7;
// otherwise stage 7 is a plain register (linear activation).
// ---------------------------------------------------------------------------
module layer_4_channel_reduce
    import layer_4_pkg::*;
#(
    parameter int    DATA_WIDTH    = 32,
    parameter int    DATA_IN_WIDTH = 1024,
    parameter int    NUM_CH        = 32,
    parameter int    IMG_SIZE      = 104,
    parameter fp32_t BIAS          = 32'h00000000,
    parameter int    LEAKY_SHIFT   = 3
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_IN_WIDTH-1:0] data_in,
    input  logic                     valid_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    output logic                     frame_last
);

    localparam int FRAME_PIX = frame_pixels(IMG_SIZE);
    localparam int CNT_W     = $clog2(FRAME_PIX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);

    genvar gi;

    // Lane unpacking
    fp32_t [NUM_CH-1:0] lane;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign lane[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Tree levels 1..5: level n adds entries 2i and 2i+1 of level n-1.
    fp32_t [15:0] l1_d, l1_q;
    fp32_t [7:0]  l2_d, l2_q;
    fp32_t [3:0]  l3_d, l3_q;
    fp32_t [1:0]  l4_d, l4_q;
    fp32_t        l5_d, l5_q;
    fp32_t        bias_d, bias_q;
    fp32_t        act_d, act_q;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_l1
            fp32_add u_add (.a_i(lane[2*gi]), .b_i(lane[2*gi+1]), .sum_o(l1_d[gi]));
        end
        for (gi = 0; gi < 8; gi++) begin : g_l2
            fp32_add u_add (.a_i(l1_q[2*gi]), .b_i(l1_q[2*gi+1]), .sum_o(l2_d[gi]));
        end
        for (gi = 0; gi < 4; gi++) begin : g_l3
            fp32_add u_add (.a_i(l2_q[2*gi]), .b_i(l2_q[2*gi+1]), .sum_o(l3_d[gi]));
        end
        for (gi = 0; gi < 2; gi++) begin : g_l4
            fp32_add u_add (.a_i(l3_q[2*gi]), .b_i(l3_q[2*gi+1]), .sum_o(l4_d[gi]));
        end
    endgenerate

    fp32_add u_l5   (.a_i(l4_q[0]), .b_i(l4_q[1]), .sum_o(l5_d));
    fp32_add u_bias (.a_i(l5_q),    .b_i(BIAS),    .sum_o(bias_d));

    // Stage 7 activation
`ifdef LAYER_4_LEAKY_RELU_EN
    localparam logic [7:0] LEAKY_EXP = 8'(LEAKY_SHIFT);

    // Multiplying by 2^-LEAKY_SHIFT is an exponent decrement; anything that
    // would fall into the denormal range is flushed to -0.0.
    always_comb begin
        act_d = bias_q;
        if (bias_q[FP32_SIGN_BIT] &&
            (bias_q[FP32_EXP_MSB:FP32_EXP_LSB] != FP32_EXP_MAX)) begin
            if (bias_q[FP32_EXP_MSB:FP32_EXP_LSB] > LEAKY_EXP) begin
                act_d[FP32_EXP_MSB:FP32_EXP_LSB] =
                    bias_q[FP32_EXP_MSB:FP32_EXP_LSB] - LEAKY_EXP;
            end else begin
                act_d = FP32_NEG_ZERO;
            end
        end
    end
`else
    assign act_d = bias_q;
`endif

    // vld_q[k] is the valid bit of stage k+1; data registers load only when
    // the valid bit shifting into their stage is set.
    logic [6:0]       vld_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_q  <= '0;
            l1_q   <= '0;
            l2_q   <= '0;
            l3_q   <= '0;
            l4_q   <= '0;
            l5_q   <= '0;
            bias_q <= '0;
            act_q  <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q <= {vld_q[5:0], valid_in};
            if (valid_in) l1_q   <= l1_d;
            if (vld_q[0]) l2_q   <= l2_d;
            if (vld_q[1]) l3_q   <= l3_d;
            if (vld_q[2]) l4_q   <= l4_d;
            if (vld_q[3]) l5_q   <= l5_d;
            if (vld_q[4]) bias_q <= bias_d;
            if (vld_q[5]) act_q  <= act_d;
            // cnt_q is the frame index of the beat currently on valid_out.
            if (vld_q[6]) begin
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign data_out   = act_q;
    assign valid_out  = vld_q[6];
    assign frame_last = vld_q[6] && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_layer_4_channel_reduce.sv
// ---------------------------------------------------------------------------
// tb_layer_4_channel_reduce
// Directed bench for layer_4_channel_reduce. Three instances share stimulus:
//   dut   : BIAS = 0.0, IMG_SIZE = 104
//   dut_b : BIAS = 1.0, IMG_SIZE = 104
//   dut_s : BIAS = 0.0, IMG_SIZE = 2 (short frame for counter/reset checks)
// Expected activation results depend on LAYER_4_LEAKY_RELU_EN.
// ---------------------------------------------------------------------------
module tb_layer_4_channel_reduce;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] data_in;
    logic          valid_in;

    logic [31:0] dout, dout_b, dout_s;
    logic        vout, vout_b, vout_s;
    logic        flast, flast_b, flast_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    layer_4_channel_reduce #(.IMG_SIZE(104), .BIAS(32'h00000000)) dut (
        .Clk(clk), .Rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout), .valid_out(vout), .frame_last(flast));

    layer_4_channel_reduce #(.IMG_SIZE(104), .BIAS(32'h3F800000)) dut_b (
        .Clk(clk), .Rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout_b), .valid_out(vout_b), .frame_last(flast_b));

    layer_4_channel_reduce #(.IMG_SIZE(2), .BIAS(32'h00000000)) dut_s (
        .Clk(clk), .Rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout_s), .valid_out(vout_s), .frame_last(flast_s));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [1023:0] fill(input logic [31:0] even_v, input logic [31:0] odd_v);
        logic [1023:0] d;
        for (int k = 0; k < 32; k++) begin
            d[32*k +: 32] = (k % 2 == 0) ? even_v : odd_v;
        end
        return d;
    endfunction

    function automatic logic [1023:0] two_lanes(input logic [31:0] l0, input logic [31:0] l1);
        logic [1023:0] d;
        d = '0;
        d[31:0]  = l0;
        d[63:32] = l1;
        return d;
    endfunction

    // Sends one beat in the current cycle N and checks valid_out is low in
    // N+6, high in N+7, and data_out matches in N+7.
    task automatic beat_check(input string tag, input logic [1023:0] d, input logic [31:0] exp);
        data_in  = d;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq({tag, "_early"}, {31'd0, vout}, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_vld"}, {31'd0, vout}, 32'd1);
        check_eq(tag, dout, exp);
    endtask

    logic [1023:0] nan_vec;
    int nout, nlast, last_idx, nlast_s, nstray, nspur, first_cyc, flast_idx;
    logic [31:0] first_data;

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", dout, 32'h0);
        check_eq("rst_valid", {31'd0, vout}, 32'd0);
        check_eq("rst_last", {31'd0, flast}, 32'd0);
        rst = 1'b0;

        beat_check("zero", '0, 32'h00000000);
        check_eq("zero_bias1", dout_b, 32'h3F800000);

        beat_check("ones", fill(32'h3F800000, 32'h3F800000), 32'h42000000);
        check_eq("ones_bias1", dout_b, 32'h42040000);

`ifdef LAYER_4_LEAKY_RELU_EN
        beat_check("neg_ones", fill(32'hBF800000, 32'hBF800000), 32'hC0800000);
`else
        beat_check("neg_ones", fill(32'hBF800000, 32'hBF800000), 32'hC2000000);
`endif

        beat_check("cancel", fill(32'h40000000, 32'hC0000000), 32'h00000000);
        nan_vec = fill(32'h40000000, 32'hC0000000);
        nan_vec[31:0] = 32'h7F800001;
        beat_check("nan_lane0", nan_vec, 32'h7FC00000);

        beat_check("mix_1_2", fill(32'h3F800000, 32'h40000000), 32'h42400000);
        beat_check("rne_tie", two_lanes(32'h3F800000, 32'h33800000), 32'h3F800000);
        beat_check("rne_up", two_lanes(32'h3F800000, 32'h33800001), 32'h3F800001);
        beat_check("denorm", two_lanes(32'h00400000, 32'h00000000), 32'h00000000);
        beat_check("overflow", two_lanes(32'h7F7FFFFF, 32'h7F7FFFFF), 32'h7F800000);
        beat_check("inf_m_inf", two_lanes(32'h7F800000, 32'hFF800000), 32'h7FC00000);
        beat_check("sub_half", two_lanes(32'h3FC00000, 32'hBF800000), 32'h3F000000);

        // Frame counter: 10816 back-to-back beats plus one into the next frame.
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        nout = 0; nlast = 0; last_idx = -1; nlast_s = 0; nstray = 0;
        data_in = fill(32'h3F800000, 32'h3F800000);
        for (int c = 0; c < 10817 + 10; c++) begin
            valid_in = (c < 10817);
            @(posedge clk); #1;
            if ((flast && !vout) || (flast_s && !vout_s)) nstray++;
            if (vout) begin
                if (flast) begin
                    nlast++;
                    last_idx = nout;
                end
                nout++;
            end
            if (vout_s && flast_s) nlast_s++;
        end
        valid_in = 1'b0;
        check_eq("frame_beats", nout, 32'd10817);
        check_eq("frame_last_cnt", nlast, 32'd1);
        check_eq("frame_last_idx", last_idx, 32'd10815);
        check_eq("frame_last_stray", nstray, 32'd0);
        check_eq("small_frame_cnt", nlast_s, 32'd2704);

        // Mid-stream reset: 4-beat burst, Rst 3 cycles after it, plus a beat
        // presented while Rst is high.
        nspur = 0;
        for (int c = 0; c < 21; c++) begin
            valid_in = (c < 4) || (c == 6);
            rst      = (c == 6);
            @(posedge clk); #1;
            if (vout || vout_b || vout_s) nspur++;
        end
        rst = 1'b0;
        valid_in = 1'b0;
        check_eq("rst_flush", nspur, 32'd0);

        // Four fresh beats: first output at input cycle + 7, frame index 0.
        nout = 0; first_cyc = -1; flast_idx = -1; nlast_s = 0; first_data = '0;
        data_in = fill(32'h3F800000, 32'h40000000);
        for (int c = 0; c < 16; c++) begin
            valid_in = (c < 4);
            @(posedge clk); #1;
            if (vout_s) begin
                if (first_cyc < 0) begin
                    first_cyc  = c + 1;
                    first_data = dout_s;
                end
                if (flast_s) begin
                    nlast_s++;
                    flast_idx = nout;
                end
                nout++;
            end
        end
        valid_in = 1'b0;
        check_eq("post_rst_latency", first_cyc, 32'd7);
        check_eq("post_rst_data", first_data, 32'h42400000);
        check_eq("post_rst_beats", nout, 32'd4);
        check_eq("post_rst_last_cnt", nlast_s, 32'd1);
        check_eq("post_rst_last_idx", flast_idx, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
